alu_iter_shifter: RTL
=====================

Name: alu_iter_shifter

Overview:
- Multi-cycle shift engine that produces the LLS (logical left shift) and ASR (arithmetic shift right) operands consumed by the ALU result multiplexer.
- Shifts one bit position per clock under a start/busy/done handshake, and holds the result stable for the mux.
- Sits directly upstream of the ALU mux. The controller selects ALUSEL 3'b100 (LLS) or 3'b101 (ASR) once done has pulsed.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op  in  1  0 = LLS, 1 = ASR; equals ALUSEL[0] of the matching mux code.
- operand_a  in  WIDTH  value to shift; sampled together with start.
- shamt  in  SHAMT_W  shift amount, 0..WIDTH-1; sampled together with start.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse: result is updated and valid.
- result  out  WIDTH  last completed shift; drives the mux LLS or ASR input.

Behaviour:
- Reset:
  - clk and rst are the only clock and reset; rst is synchronous and active-high.
  - rst=1 at an edge forces state=IDLE, result=0, busy=0, done=0, with internal count, op and working register cleared.
  - rst overrides start and any shift in progress. A reset mid-operation aborts the shift and discards the partial value; result reads 0 afterwards.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge latches operand_a into the working register, latches op, and loads count=shamt.
  - If shamt=0, go to DONE. Otherwise go to SHIFT.
- SHIFT, once per edge:
  - LLS: working = working<<1, zero-filled.
  - ASR: working = {working[WIDTH-1], working[WIDTH-1:1]}, sign-replicated.
  - count decrements by 1. The edge on which count goes 1->0 also moves the state to DONE.
- DONE:
  - done=1 for exactly one cycle and busy=1.
  - At the next edge, result <= working and state returns to IDLE.
  - result is registered at entry to DONE, so it is already valid while done=1.
- Latency: done is asserted exactly shamt+1 cycles after the edge that sampled start, for shamt 0..WIDTH-1.
- Holding result: result changes only on completion of an operation or on reset, and holds across idle cycles and across the next operation's SHIFT cycles.
- Start while busy=1 (SHIFT or DONE): ignored, not queued. A start held high through DONE is accepted at the first IDLE edge, so back-to-back operations have one idle-cycle gap.
- operand_a, shamt and op may change freely after the accepting edge without affecting the operation in flight.
- Boundaries:
  - shamt=WIDTH-1 with ASR on a negative operand yields all ones; with LLS it yields operand_a[0] in bit WIDTH-1 and zeros elsewhere.
  - There is no carry-out or overflow output.

Decomposition:
- Shared ALU package holds:
  - op codes SHIFT_OP_LLS=1'b0 and SHIFT_OP_ASR=1'b1;
  - ALUSEL constants AND=3'b000, OR=3'b001, RES=3'b010, SUM=3'b011, LLS=3'b100, ASR=3'b101;
  - the 2-bit state encodings IDLE, SHIFT, DONE.
- Single module; no sub-module is warranted. The one-bit shift step stays inline.

Test Plan:
- Reset 2 cycles, then start, op=0, operand_a=5, shamt=1 -> busy on the next cycle; done at cycle +2 with result=10; result holds 10 afterwards.
- start, op=1, operand_a=100, shamt=2 -> done at cycle +3 with result=25.
- start, op=1, operand_a=0x80000000, shamt=31 -> done exactly 32 cycles later with result=0xFFFFFFFF.
- start, op=0, operand_a=23, shamt=0 -> done at cycle +1 with result=23. Then start, op=1, operand_a=0xFFFFFFF0, shamt=4 -> result=0xFFFFFFFF.
- start, op=0, operand_a=1, shamt=8; at cycle +2 pulse start with operand_a=7, shamt=1; at cycle +4 change operand_a to 3 -> second start ignored; done at cycle +9 with result=256.
- start, op=0, operand_a=0xA, shamt=20; assert rst at cycle +5 -> next cycle busy=0, done=0, result=0, and no done pulse follows. A fresh start with operand_a=2, op=0, shamt=1 then gives result=4.

Source files
------------

// File: rtl/alu_iter_shifter_pkg.sv
// rtl/alu_iter_shifter_pkg.sv - shared ALU op codes, mux selects and shifter state encodings
package alu_iter_shifter_pkg;

  localparam logic SHIFT_OP_LLS = 1'b0;
  localparam logic SHIFT_OP_ASR = 1'b1;

  localparam logic [2:0] ALUSEL_AND = 3'b000;
  localparam logic [2:0] ALUSEL_OR  = 3'b001;
  localparam logic [2:0] ALUSEL_RES = 3'b010;
  localparam logic [2:0] ALUSEL_SUM = 3'b011;
  localparam logic [2:0] ALUSEL_LLS = 3'b100;
  localparam logic [2:0] ALUSEL_ASR = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/alu_iter_shifter.sv
// rtl/alu_iter_shifter.sv - one-bit-per-clock LLS/ASR engine feeding the ALU result mux
module alu_iter_shifter
  import alu_iter_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  shift_state_e       state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   work_step;

  always_comb begin
    work_step = (op_q == SHIFT_OP_ASR) ? {work_q[WIDTH-1], work_q[WIDTH-1:1]}
                                       : {work_q[WIDTH-2:0], 1'b0};
  end

  // result is loaded on the edge entering DONE so it is valid while done is high
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    work_d   = work_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = operand_a;
          op_d    = op;
          count_d = shamt;
          if (shamt == '0) begin
            state_d  = DONE;
            result_d = operand_a;
            done_d   = 1'b1;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = work_step;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d  = DONE;
          result_d = work_step;
          done_d   = 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        result_d = work_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      work_q   <= work_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
